// File: rtl/caxi4dma_fifo_pkg.sv
// Shared constants and helpers for the AXI4 DMA RAM FIFO controller.
// RAM_DATA_W : width of every word stored in the descriptor/data RAM.
// rd_latency : RAM read latency for a given PIPELINED setting.
// skid_depth : output skid FIFO depth that absorbs every outstanding read.
package caxi4dma_fifo_pkg;

    localparam int unsigned RAM_DATA_W = 32;

    function automatic int unsigned rd_latency(input int unsigned pipelined);
        return 1 + pipelined;
    endfunction

    // One slot per read that can be in flight plus one for the word being consumed.
    function automatic int unsigned skid_depth(input int unsigned pipelined);
        return rd_latency(pipelined) + 1;
    endfunction

endpackage

// File: rtl/caxi4dma_skid_fifo.sv
// Small register-based FIFO that re-times RAM read data onto the output stream.
// Entry 0 is always the head, so the head is a plain register.
// Ports:
//   clk_i, rst_i       clock and synchronous active-high reset
//   clear_i            synchronous clear of all entries (push ignored)
//   push_i/push_data_i write one word; caller guarantees no overrun
//   pop_i              drop the head; caller guarantees not empty
//   valid_o, head_o    registered non-empty flag and head word
//   cnt_o              number of stored words
module caxi4dma_skid_fifo #(
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] head_o,
    output logic [CNT_W-1:0]  cnt_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d, wr_idx;
    logic              valid_q, valid_d;

    always_comb begin
        mem_d  = mem_q;
        cnt_d  = cnt_q;
        // A simultaneous pop shifts everything down, so the free slot moves with it.
        wr_idx = pop_i ? cnt_q - CNT_W'(1) : cnt_q;
        if (pop_i) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
            mem_d[DEPTH - 1] = '0;
        end
        if (push_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    mem_d[i] = push_data_i;
                end
            end
        end
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (clear_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_d[i] = '0;
            end
            cnt_d = '0;
        end
        valid_d = (cnt_d != '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;
    assign head_o  = mem_q[0];
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/caxi4dma_ram_fifo_ctrl.sv
// Streaming FIFO controller driving both ports of the DMA dual-port RAM.
// Input words are written to the RAM, read back with the RAM's fixed latency and
// re-timed through a skid FIFO onto the output stream.
// Ports:
//   CLOCK, RESET                  clock and synchronous active-high reset
//   flush                         synchronous clear of all contents
//   in_valid/in_data/in_ready     input stream
//   out_valid/out_data/out_ready  output stream (registered valid/data)
//   count                         words held in RAM + in flight + skid
//   ram_wr_*                      RAM write port (active-low enable)
//   ram_rd_*                      RAM read port
module caxi4dma_ram_fifo_ctrl
    import caxi4dma_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned PIPELINED  = 1
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [RAM_DATA_W-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [RAM_DATA_W-1:0] out_data,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  ram_wr_en_n,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [RAM_DATA_W-1:0] ram_wr_data,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [RAM_DATA_W-1:0] ram_rd_data
);

    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
    localparam int unsigned RD_LAT     = rd_latency(PIPELINED);
    localparam int unsigned SKID_DEPTH = skid_depth(PIPELINED);
    localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int unsigned OCC_W      = SKID_CNT_W + 1;
    localparam logic [ADDR_WIDTH:0] RAM_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic [RD_LAT-1:0]     infl_q, infl_d;
    logic [ADDR_WIDTH+1:0] count_q, count_d;
    logic [SKID_CNT_W-1:0] skid_cnt;
    logic [OCC_W-1:0]      infl_cnt, occ_now, occ_limit;
    logic                  wr_fire, pop;

    assign in_ready    = (ram_cnt_q != RAM_FULL) & ~RESET & ~flush;
    assign wr_fire     = in_valid & in_ready;
    assign pop         = out_valid & out_ready;
    assign ram_wr_en_n = ~wr_fire;
    assign ram_wr_addr = wr_ptr_q;
    assign ram_wr_data = in_data;
    assign ram_rd_addr = rd_ptr_q;
    assign count       = count_q;

    // Issue a read only if its data is guaranteed a skid slot on return, counting
    // the slot freed by a pop this cycle.
    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            infl_cnt = infl_cnt + OCC_W'(infl_q[i]);
        end
        occ_now   = OCC_W'(skid_cnt) + infl_cnt;
        occ_limit = OCC_W'(SKID_DEPTH) + OCC_W'(pop);
        ram_rd_en = (ram_cnt_q != '0) && (occ_now < occ_limit);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(wr_fire);
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(ram_rd_en);
        case ({wr_fire, ram_rd_en})
            2'b10:   ram_cnt_d = ram_cnt_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   ram_cnt_d = ram_cnt_q - (ADDR_WIDTH + 1)'(1);
            default: ram_cnt_d = ram_cnt_q;
        endcase
        // Words move RAM -> flight -> skid without changing the total held.
        case ({wr_fire, pop})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 2)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 2)'(1);
            default: count_d = count_q;
        endcase
        infl_d    = '0;
        infl_d[0] = ram_rd_en;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            infl_d[i] = infl_q[i - 1];
        end
        // Clearing the in-flight tags makes late RAM returns fall on the floor.
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            ram_cnt_d = '0;
            count_d   = '0;
            infl_d    = '0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            count_q   <= '0;
            infl_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            count_q   <= count_d;
            infl_q    <= infl_d;
        end
    end

    caxi4dma_skid_fifo #(
        .DEPTH  (SKID_DEPTH),
        .DATA_W (RAM_DATA_W)
    ) u_skid (
        .clk_i       (CLOCK),
        .rst_i       (RESET),
        .clear_i     (flush),
        .push_i      (infl_q[RD_LAT-1]),
        .push_data_i (ram_rd_data),
        .pop_i       (pop),
        .valid_o     (out_valid),
        .head_o      (out_data),
        .cnt_o       (skid_cnt)
    );

endmodule
